// File: rtl/deck_pkg.sv
`default_nettype none
// ============================================================================
// Module      : deck_pkg
// Description : Shared constants, state encoding and helpers for the card
//               deck shuffler and its LFSR.
// Contents    : DECK_SIZE, NUM_RANKS, rank constants, SEED_ZERO_SUB,
//               state_t, ordered_rank(), shuffle_mask()
// Revision    : 1.0 - initial release
// ============================================================================
package deck_pkg;

  localparam int DECK_SIZE = 52;
  localparam int NUM_RANKS = 13;

  localparam logic [3:0] RANK_ACE   = 4'd1;
  localparam logic [3:0] RANK_JACK  = 4'd11;
  localparam logic [3:0] RANK_QUEEN = 4'd12;
  localparam logic [3:0] RANK_KING  = 4'd13;

  // An all-zero LFSR state would lock up, so a zero seed is replaced by this.
  localparam logic [5:0] SEED_ZERO_SUB = 6'b101010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHUF = 2'd1,
    DEAL = 2'd2
  } state_t;

  // Rank stored at position idx of a freshly ordered deck: A..K repeating.
  function automatic logic [3:0] ordered_rank(input int idx);
    return 4'((idx % NUM_RANKS) + 1);
  endfunction

  // Smallest 2^k-1 that covers i; used to draw a swap candidate 0..mask.
  function automatic logic [5:0] shuffle_mask(input logic [5:0] i);
    if (i <= 6'd1)       return 6'd1;
    else if (i <= 6'd3)  return 6'd3;
    else if (i <= 6'd7)  return 6'd7;
    else if (i <= 6'd15) return 6'd15;
    else if (i <= 6'd31) return 6'd31;
    else                 return 6'd63;
  endfunction

endpackage
`default_nettype wire

// File: rtl/deck_shuffler_lfsr6.sv
`default_nettype none
// ============================================================================
// Module      : lfsr6
// Description : 6-bit Fibonacci LFSR, polynomial x^6+x^5+1 (maximal, period
//               63). Load takes priority over step; a zero seed is replaced
//               so the register can never enter the all-zero lock-up state.
// Ports       : clk, reset (sync, active-high), load, seed[5:0], step,
//               value[5:0] (current LFSR state)
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr6
  import deck_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [5:0] seed,
  input  logic       step,
  output logic [5:0] value
);

  logic feedback;

  assign feedback = value[5] ^ value[4];

  always_ff @(posedge clk) begin
    if (reset) begin
      value <= SEED_ZERO_SUB;
    end else if (load) begin
      value <= (seed == 6'd0) ? SEED_ZERO_SUB : seed;
    end else if (step) begin
      value <= {value[4:0], feedback};
    end
  end

endmodule
`default_nettype wire

// File: rtl/deck_shuffler.sv
`default_nettype none
// ============================================================================
// Module      : deck_shuffler
// Description : 52-card rank deck held in registers, shuffled in place by a
//               seeded Fisher-Yates pass (one candidate per cycle, rejection
//               sampling on an LFSR draw) and dealt one card per request.
// Ports       : clk, reset (sync, active-high)
//               shuffle_start / shuffle_ready / seed[5:0] - shuffle handshake
//               card_start / card_ready / card[3:0]        - deal handshake
//               card_overflow - sticky, deal requested on empty deck
//               cards_left[5:0] - undealt cards remaining
// Revision    : 1.0 - initial release
// ============================================================================
module deck_shuffler
  import deck_pkg::*;
#(
  parameter int DEAL_LAT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       shuffle_start,
  output logic       shuffle_ready,
  input  logic [5:0] seed,
  input  logic       card_start,
  output logic       card_ready,
  output logic [3:0] card,
  output logic       card_overflow,
  output logic [5:0] cards_left
);

  localparam int LAT_W = (DEAL_LAT > 1) ? $clog2(DEAL_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(DEAL_LAT - 1);

  state_t           state, state_next;
  logic             shuffle_q, card_q;
  logic             shuffle_edge, card_edge;
  logic [3:0]       deck [DECK_SIZE];
  logic [5:0]       idx;        // Fisher-Yates position being filled
  logic [5:0]       ptr;        // next card to deal
  logic [LAT_W-1:0] lat_cnt;
  logic [5:0]       lfsr_val;
  logic [5:0]       cand;
  logic             accept;
  logic             deck_empty;
  logic             shuf_done;
  logic             deal_done;

  assign shuffle_edge = shuffle_start & ~shuffle_q;
  assign card_edge    = card_start & ~card_q;
  assign deck_empty   = (ptr == 6'(DECK_SIZE));

  // Candidate index; out-of-range draws are rejected and retried next cycle.
  assign cand      = lfsr_val & shuffle_mask(idx);
  assign accept    = (cand <= idx);
  assign shuf_done = (state == SHUF) && accept && (idx == 6'd1);
  assign deal_done = (state == DEAL) && (lat_cnt == LAT_LAST);

  lfsr6 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  ((state == IDLE) && shuffle_edge),
    .seed  (seed),
    .step  (state == SHUF),
    .value (lfsr_val)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic; a shuffle edge outranks a simultaneous card edge.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (shuffle_edge)                  state_next = SHUF;
        else if (card_edge && !deck_empty) state_next = DEAL;
      end
      SHUF:    if (shuf_done) state_next = IDLE;
      DEAL:    if (deal_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    shuffle_ready = (state != SHUF);
    card_ready    = (state == IDLE);
  end

  // Datapath: edge detectors, deck storage, pointers and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      shuffle_q     <= 1'b0;
      card_q        <= 1'b0;
      card          <= 4'd0;
      card_overflow <= 1'b0;
      cards_left    <= 6'(DECK_SIZE);
      ptr           <= 6'd0;
      idx           <= 6'(DECK_SIZE - 1);
      lat_cnt       <= '0;
      for (int k = 0; k < DECK_SIZE; k++) deck[k] <= ordered_rank(k);
    end else begin
      shuffle_q <= shuffle_start;
      card_q    <= card_start;
      case (state)
        IDLE: begin
          if (shuffle_edge) begin
            for (int k = 0; k < DECK_SIZE; k++) deck[k] <= ordered_rank(k);
            idx           <= 6'(DECK_SIZE - 1);
            ptr           <= 6'd0;
            card_overflow <= 1'b0;
            cards_left    <= 6'(DECK_SIZE);
          end else if (card_edge) begin
            if (deck_empty) card_overflow <= 1'b1;
            else            lat_cnt       <= '0;
          end
        end
        SHUF: begin
          if (accept) begin
            deck[idx]  <= deck[cand];
            deck[cand] <= deck[idx];
            idx        <= idx - 6'd1;
          end
        end
        DEAL: begin
          if (deal_done) begin
            card       <= deck[ptr];
            ptr        <= ptr + 6'd1;
            cards_left <= cards_left - 6'd1;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
